// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine coin front end and its controller.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_ISSUE,
    ST_WAIT,
    ST_REFUND
  } vend_state_t;

  localparam logic [5:0] COIN_1     = 6'd1;
  localparam logic [5:0] COIN_5     = 6'd5;
  localparam logic [5:0] COIN_10    = 6'd10;
  localparam logic [5:0] COIN_20    = 6'd20;
  localparam logic [5:0] CREDIT_MAX = 6'd63;

  localparam logic [2:0] PROD_SANDWICH  = 3'd0;
  localparam logic [2:0] PROD_CHOCOLATE = 3'd1;
  localparam logic [2:0] PROD_WATER     = 3'd2;
  localparam logic [2:0] PROD_COFFEE    = 3'd3;
  localparam logic [2:0] PROD_TEA       = 3'd4;

  function automatic logic [5:0] coinValue(input logic [1:0] coinType);
    case (coinType)
      2'b00:   coinValue = COIN_1;
      2'b01:   coinValue = COIN_5;
      2'b10:   coinValue = COIN_10;
      default: coinValue = COIN_20;
    endcase
  endfunction

endpackage

// File: rtl/vend_timeout_counter.sv
// CREDIT inactivity counter; only exists in builds with VEND_TIMEOUT_EN defined.
`ifdef VEND_TIMEOUT_EN
module vend_timeout_counter #(
  parameter logic [15:0] LIMIT = 16'd999
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count;

  // The count parks at LIMIT; the owner leaves CREDIT on expiry and clears it on re-entry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 16'd1;
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule
`endif

// File: rtl/vend_coin_front.sv
// Coin accumulation, selection latch and vend/refund sequencing ahead of the vending controller.
// Optional inactivity auto-refund in CREDIT is enabled by defining VEND_TIMEOUT_EN.
module vend_coin_front
  import vend_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       select,
  input  logic [2:0] product_id_in,
  input  logic       vm_in,
  input  logic       sugar_in,
  input  logic       cancel,
  input  logic [5:0] money_left,
  input  logic       product_ready,
  output logic [5:0] money,
  output logic [2:0] product_id,
  output logic       vm,
  output logic       sugar,
  output logic       vend_req,
  output logic       coin_reject,
  output logic       refund_valid,
  output logic [5:0] refund_amount,
  output logic       vend_done,
  output logic       busy
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must fit the 16-bit inactivity counter");
  end

  vend_state_t state, nextState;
  logic [5:0]  credit, refundAmt;
  logic [6:0]  creditSum;
  logic        coinFits, coinAccept, takeCancel, takeSelect, timeoutHit, timeoutExpired;
  logic        coinRejectQ, vendDoneQ;

`ifdef VEND_TIMEOUT_EN
  vend_timeout_counter #(
    .LIMIT(16'(TIMEOUT_CYCLES - 1))
  ) uTimeout (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .clear  (coinAccept),
    .enable (state == ST_CREDIT),
    .expired(timeoutExpired)
  );
`else
  assign timeoutExpired = 1'b0;
`endif

  // Seven-bit sum so an over-limit coin is refused rather than wrapping the credit.
  assign creditSum = {1'b0, credit} + {1'b0, coinValue(coin_type)};
  assign coinFits  = creditSum <= {1'b0, CREDIT_MAX};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    nextState  = state;
    coinAccept = 1'b0;
    takeCancel = 1'b0;
    takeSelect = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (coin_valid) begin
          coinAccept = 1'b1;
          nextState  = ST_CREDIT;
        end
      end
      ST_CREDIT: begin
        if (cancel) begin
          takeCancel = 1'b1;
          nextState  = ST_REFUND;
        end else if (select) begin
          takeSelect = 1'b1;
          nextState  = ST_ISSUE;
        end else if (timeoutExpired) begin
          timeoutHit = 1'b1;
          nextState  = ST_REFUND;
        end else if (coin_valid && coinFits) begin
          coinAccept = 1'b1;
        end
      end
      ST_ISSUE:  nextState = ST_WAIT;
      ST_WAIT:   nextState = (money_left != 6'd0) ? ST_REFUND : ST_IDLE;
      ST_REFUND: nextState = ST_IDLE;
      default:   nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      credit      <= '0;
      refundAmt   <= '0;
      product_id  <= '0;
      vm          <= 1'b0;
      sugar       <= 1'b0;
      coinRejectQ <= 1'b0;
      vendDoneQ   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample pre-edge values.
      state       <= nextState;
      coinRejectQ <= coin_valid && !coinAccept;
      vendDoneQ   <= (state == ST_WAIT) && product_ready;

      if (coinAccept) begin
        credit <= creditSum[5:0];
      end else if (state == ST_WAIT || state == ST_REFUND) begin
        credit <= '0;
      end

      if (takeCancel || timeoutHit) begin
        refundAmt <= credit;
      end else if (state == ST_WAIT) begin
        refundAmt <= money_left;
      end

      if (takeSelect) begin
        product_id <= product_id_in;
        vm         <= vm_in;
        sugar      <= sugar_in;
      end
    end
  end

  assign money         = credit;
  assign vend_req      = (state == ST_ISSUE);
  assign refund_valid  = (state == ST_REFUND);
  assign refund_amount = refund_valid ? refundAmt : 6'd0;
  assign coin_reject   = coinRejectQ;
  assign vend_done     = vendDoneQ;
  assign busy          = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_REFUND);

endmodule

// File: tb/tb_vend_coin_front.sv
// Directed bench for vend_coin_front; refund and vend-done results flow through a scoreboard.
module tb_vend_coin_front;
  import vend_pkg::*;

`ifdef VEND_TIMEOUT_EN
  localparam int TimeoutCycles = 8;
`else
  localparam int TimeoutCycles = 1000;
`endif

  localparam logic [1:0] C1 = 2'b00, C5 = 2'b01, C10 = 2'b10, C20 = 2'b11;

  logic       CLK, RST_N;
  logic       coin_valid, select, vm_in, sugar_in, cancel, product_ready;
  logic [1:0] coin_type;
  logic [2:0] product_id_in, product_id;
  logic [5:0] money_left, money, refund_amount;
  logic       vm, sugar, vend_req, coin_reject, refund_valid, vend_done, busy;

  int errors = 0;
  int checks = 0;
  int refundQ[$];
  int doneQ[$];

  vend_coin_front #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .select       (select),
    .product_id_in(product_id_in),
    .vm_in        (vm_in),
    .sugar_in     (sugar_in),
    .cancel       (cancel),
    .money_left   (money_left),
    .product_ready(product_ready),
    .money        (money),
    .product_id   (product_id),
    .vm           (vm),
    .sugar        (sugar),
    .vend_req     (vend_req),
    .coin_reject  (coin_reject),
    .refund_valid (refund_valid),
    .refund_amount(refund_amount),
    .vend_done    (vend_done),
    .busy         (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic coin(input logic [1:0] ct);
    coin_valid = 1'b1;
    coin_type  = ct;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic checkRefund(input string tag);
    int expAmt;
    expAmt = -1;
    if (refundQ.size() != 0) expAmt = refundQ.pop_front();
    check({tag, "_refund_valid"}, 32'(refund_valid), 32'd1);
    check({tag, "_refund_amount"}, 32'(refund_amount), 32'(expAmt));
  endtask

  task automatic checkDone(input string tag);
    int expDone;
    expDone = -1;
    if (doneQ.size() != 0) expDone = doneQ.pop_front();
    check({tag, "_vend_done"}, 32'(vend_done), 32'(expDone));
  endtask

  // Select in CREDIT, play the controller's reply, then check n+1..n+3.
  task automatic purchase(input string tag, input int credit, input logic [2:0] id,
                          input logic v, input logic s, input int left, input logic ready,
                          input bit pokeCoin);
    select = 1'b1; product_id_in = id; vm_in = v; sugar_in = s;
    doneQ.push_back(int'(ready));
    if (left != 0) refundQ.push_back(left);
    tick();
    select = 1'b0;
    check({tag, "_vend_req"}, 32'(vend_req), 32'd1);
    check({tag, "_latch"}, 32'({product_id, vm, sugar}), 32'({id, v, s}));
    check({tag, "_money_issue"}, 32'(money), 32'(credit));
    money_left = 6'(left); product_ready = ready;
    if (pokeCoin) begin
      coin_valid = 1'b1; coin_type = C20;
    end
    tick();
    coin_valid = 1'b0;
    check({tag, "_wait"}, 32'({vend_req, busy}), 32'({1'b0, 1'b1}));
    check({tag, "_money_wait"}, 32'(money), 32'(credit));
    if (pokeCoin) check({tag, "_busy_coin_reject"}, 32'(coin_reject), 32'd1);
    tick();
    money_left = '0; product_ready = 1'b0;
    checkDone(tag);
    check({tag, "_money_after"}, 32'(money), 32'd0);
    if (left != 0) begin
      checkRefund(tag);
      tick();
    end
    check({tag, "_idle"}, 32'({refund_valid, busy}), 32'd0);
  endtask

  initial begin
    RST_N = 1'b0; coin_valid = 1'b0; coin_type = C1; select = 1'b0; cancel = 1'b0;
    product_id_in = '0; vm_in = 1'b0; sugar_in = 1'b0; money_left = '0; product_ready = 1'b0;
    tick(); tick();
    check("reset_outputs", 32'({money, product_id, vm, sugar, vend_req, coin_reject,
                                refund_valid, refund_amount, vend_done, busy}), 32'd0);
    RST_N = 1'b1;
    tick();

    // IDLE ignores select and cancel.
    select = 1'b1; cancel = 1'b1; product_id_in = PROD_WATER; vm_in = 1'b1;
    tick();
    select = 1'b0; cancel = 1'b0;
    check("idle_ignore", 32'({vend_req, refund_valid, busy, product_id, vm}), 32'd0);

    // Accumulate to the 63 ceiling, then a refused coin.
    coin(C20); check("acc_20", 32'(money), 32'd20);
    coin(C20); check("acc_40", 32'(money), 32'd40);
    coin(C20); check("acc_60", 32'(money), 32'd60);
    coin(C1);  check("acc_61", 32'(money), 32'd61);
    coin(C1);  check("acc_62", 32'(money), 32'd62);
    coin(C1);  check("acc_63", 32'({money, coin_reject}), 32'({6'd63, 1'b0}));
    coin(C5);  check("acc_over", 32'({money, coin_reject}), 32'({6'd63, 1'b1}));
    tick();    check("acc_reject_pulse", 32'({money, coin_reject}), 32'({6'd63, 1'b0}));
    cancel = 1'b1; refundQ.push_back(63);
    tick();
    cancel = 1'b0;
    checkRefund("acc_cancel");
    check("acc_cancel_busy", 32'({busy, vend_req}), 32'({1'b1, 1'b0}));
    tick();
    check("acc_cleared", 32'({money, refund_valid, refund_amount, busy}), 32'd0);

    // Exact purchase, change return, controller error return.
    coin(C20);
    purchase("exact", 20, PROD_SANDWICH, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    coin(C20);
    purchase("change", 20, PROD_COFFEE, 1'b1, 1'b1, 8, 1'b1, 1'b0);
    coin(C10);
    purchase("error", 10, PROD_COFFEE, 1'b0, 1'b0, 10, 1'b0, 1'b1);

    // Cancel beats select beats coin in one cycle.
    coin(C10); coin(C5);
    check("prio_credit", 32'(money), 32'd15);
    cancel = 1'b1; select = 1'b1; product_id_in = PROD_TEA; vm_in = 1'b1;
    coin_valid = 1'b1; coin_type = C20; refundQ.push_back(15);
    tick();
    cancel = 1'b0; select = 1'b0; coin_valid = 1'b0;
    checkRefund("prio");
    check("prio_side", 32'({coin_reject, vend_req}), 32'({1'b1, 1'b0}));
    check("prio_latch_held", 32'({product_id, vm}), 32'({PROD_COFFEE, 1'b0}));
    tick();
    check("prio_idle", 32'({money, busy}), 32'd0);

    // Idle credit: auto-refund with the timeout, held forever without it.
    coin(C5);
`ifdef VEND_TIMEOUT_EN
    repeat (TimeoutCycles - 1) tick();
    check("timeout_not_yet", 32'({refund_valid, money}), 32'({1'b0, 6'd5}));
    refundQ.push_back(5);
    tick();
    checkRefund("timeout");
    tick();
`else
    repeat (20) tick();
    check("hold_credit", 32'({money, busy, refund_valid}), 32'({6'd5, 1'b0, 1'b0}));
    cancel = 1'b1; refundQ.push_back(5);
    tick();
    cancel = 1'b0;
    checkRefund("hold_cancel");
    tick();
`endif
    check("credit_gone", 32'(money), 32'd0);

    // Reset in WAIT discards the transaction without a refund.
    coin(C20);
    select = 1'b1; product_id_in = PROD_CHOCOLATE; vm_in = 1'b1; sugar_in = 1'b1;
    tick();
    select = 1'b0; money_left = 6'd5; product_ready = 1'b1;
    tick();
    check("rst_in_wait", 32'({busy, vend_req, money}), 32'({1'b1, 1'b0, 6'd20}));
    #1 RST_N = 1'b0;
    #1 check("rst_outputs", 32'({money, product_id, vm, sugar, vend_req, coin_reject,
                                 refund_valid, refund_amount, vend_done, busy}), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    money_left = '0; product_ready = 1'b0;
    check("rst_no_refund", 32'({refund_valid, vend_done, money, busy}), 32'd0);

    check("scoreboard_drained", 32'(refundQ.size() + doneQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
